window_line_buffer: RTL and testbench

WINDOW_LINE_BUFFER -- requirements
Module: window_line_buffer

---
 rtl/window_line_buffer.sv | 152 +++++++++++++++
 tb/tb_window_line_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/window_line_buffer.sv
// Sliding-window line buffer: turns a raster stream into vertical window
// columns of NUM_LINES+1 taps (current word plus the same column from the
// previous NUM_LINES rows). Taps from rows not yet filled are forced to zero.
module window_line_buffer #(
  parameter int DATA_W    = 64,
  parameter int MAX_WIDTH = 8192,
  parameter int NUM_LINES = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [31:0]                          curr_width,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [DATA_W-1:0]                    s_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [(NUM_LINES+1)*DATA_W-1:0]      m_data,
  output logic [31:0]                          m_col,
  output logic                                 m_last_col,
  output logic [$clog2(NUM_LINES+2)-1:0]       m_rows_valid
);

  localparam int CW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int WW = $clog2(MAX_WIDTH + 1);
  localparam int RW = $clog2(NUM_LINES + 2);
  localparam int OW = (NUM_LINES + 1) * DATA_W;

  typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;

  // Zero width is treated as one word, oversize widths are limited to the RAM depth.
  function automatic logic [WW-1:0] clamp_width(input logic [31:0] cw);
    if (cw == 32'd0)
      return WW'(1);
    else if (cw > 32'(MAX_WIDTH))
      return WW'(MAX_WIDTH);
    else
      return WW'(cw);
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     col_p0;
  logic [RW-1:0]     row_p0;
  logic [WW-1:0]     width_p0;
  logic [WW-1:0]     eff_w;
  logic              accept;
  logic              wrap;
  logic [DATA_W-1:0] line_mem [NUM_LINES][MAX_WIDTH];
  logic [DATA_W-1:0] rd_p0 [NUM_LINES];
  logic [OW-1:0]     win_p0;

  logic              vld_p1;
  logic [OW-1:0]     data_p1;
  logic [CW-1:0]     col_p1;
  logic              last_p1;
  logic [RW-1:0]     rv_p1;

  assign s_ready = !vld_p1 || m_ready;
  assign accept  = s_valid && s_ready && !flush && !rst;
  // The width in force for this beat: live (clamped) input while EMPTY, latched otherwise.
  assign eff_w   = (state_q == EMPTY) ? clamp_width(curr_width) : width_p0;
  assign wrap    = (WW'(col_p0) == (eff_w - WW'(1)));

  // Read every line at the shared column pointer, then build the masked window column.
  always_comb begin
    win_p0 = '0;
    win_p0[DATA_W-1:0] = s_data;
    for (int k = 0; k < NUM_LINES; k++) begin
      rd_p0[k] = line_mem[k][col_p0];
      if (RW'(k + 1) <= row_p0)
        win_p0[(k+1)*DATA_W +: DATA_W] = rd_p0[k];
    end
  end

  // Stage p0 -> RAM: shift the column down one line on each accepted beat.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_mem[0][col_p0] <= s_data;
      for (int k = 1; k < NUM_LINES; k++)
        line_mem[k][col_p0] <= line_mem[k-1][col_p0];
    end
  end

  // FSM state register; flush and reset both restart the frame.
  always_ff @(posedge clk) begin
    if (rst || flush)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  // FSM next state: first beat leaves EMPTY, the wrap that completes NUM_LINES rows enters FULL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept)
               state_d = (wrap && row_p0 == RW'(NUM_LINES - 1)) ? FULL : FILL;
      FILL:  if (accept && wrap && row_p0 == RW'(NUM_LINES - 1))
               state_d = FULL;
      FULL:  state_d = FULL;
      default: state_d = EMPTY;
    endcase
  end

  // Column/row counters and the width latched on the first beat of a frame.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      col_p0 <= '0;
      row_p0 <= '0;
      if (rst)
        width_p0 <= WW'(1);
    end else if (accept) begin
      if (state_q == EMPTY)
        width_p0 <= eff_w;
      if (wrap) begin
        col_p0 <= '0;
        if (row_p0 < RW'(NUM_LINES))
          row_p0 <= row_p0 + RW'(1);
      end else begin
        col_p0 <= col_p0 + CW'(1);
      end
    end
  end

  // Stage p0 -> p1: single output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      col_p1  <= '0;
      last_p1 <= 1'b0;
      rv_p1   <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= win_p0;
      col_p1  <= col_p0;
      last_p1 <= wrap;
      rv_p1   <= row_p0 + RW'(1);
    end else if (m_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign m_valid      = vld_p1;
  assign m_data       = data_p1;
  assign m_col        = 32'(col_p1);
  assign m_last_col   = last_p1;
  assign m_rows_valid = rv_p1;

endmodule

// File: tb/tb_window_line_buffer.sv
// Directed-plus-random bench for window_line_buffer, checked against a
// frame-history reference model (every word of the current frame kept in a queue).
module tb_window_line_buffer;

  localparam int DW  = 16;
  localparam int MW  = 16;
  localparam int NL  = 2;
  localparam int OW  = (NL + 1) * DW;
  localparam int RVW = $clog2(NL + 2);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           flush = 1'b0;
  logic [31:0]    curr_width = 32'd4;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [DW-1:0]  s_data = '0;
  logic           m_valid;
  logic           m_ready = 1'b1;
  logic [OW-1:0]  m_data;
  logic [31:0]    m_col;
  logic           m_last_col;
  logic [RVW-1:0] m_rows_valid;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [DW-1:0] frm [$];
  int            wq;
  bit            exp_valid;
  logic [OW-1:0] exp_data;
  int            exp_col;
  bit            exp_last;
  int            exp_rv;

  window_line_buffer #(.DATA_W(DW), .MAX_WIDTH(MW), .NUM_LINES(NL)) dut (
    .clk(clk), .rst(rst), .flush(flush), .curr_width(curr_width),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_col(m_col), .m_last_col(m_last_col), .m_rows_valid(m_rows_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampw(input logic [31:0] cw);
    if (cw == 0) return 1;
    if (cw > MW) return MW;
    return int'(cw);
  endfunction

  // Beat n of a frame of width W sits at row n/W, column n%W; tap k is word n-k*W.
  task automatic model_accept(input logic [DW-1:0] d);
    int n, r, c, rr;
    n = frm.size();
    if (n == 0) wq = clampw(curr_width);
    frm.push_back(d);
    r  = n / wq;
    c  = n % wq;
    rr = (r > NL) ? NL : r;
    exp_data = '0;
    for (int k = 0; k <= rr; k++)
      exp_data[k*DW +: DW] = frm[n - k*wq];
    exp_valid = 1'b1;
    exp_col   = c;
    exp_last  = (c == wq - 1);
    exp_rv    = rr + 1;
  endtask

  task automatic check_outputs();
    chk("m_valid", 64'(m_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("m_data", 64'(m_data), 64'(exp_data));
      chk("m_col", 64'(m_col), 64'(exp_col));
      chk("m_last_col", 64'(m_last_col), 64'(exp_last));
      chk("m_rows_valid", 64'(m_rows_valid), 64'(exp_rv));
    end
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit mr, input bit fl);
    bit acc;
    @(negedge clk);
    s_valid = v; s_data = d; m_ready = mr; flush = fl;
    #1;
    chk("s_ready", 64'(s_ready), 64'(!exp_valid || mr));
    acc = v && (!exp_valid || mr) && !fl;
    @(posedge clk);
    #1;
    s_valid = 1'b0; flush = 1'b0;
    if (fl) begin
      frm.delete();
      exp_valid = 1'b0;
    end else if (acc) begin
      model_accept(d);
    end else if (mr) begin
      exp_valid = 1'b0;
    end
    check_outputs();
  endtask

  task automatic do_reset(input bit v, input bit mr);
    @(negedge clk);
    rst = 1'b1; s_valid = v; s_data = DW'($urandom); m_ready = mr;
    @(posedge clk);
    #1;
    rst = 1'b0; s_valid = 1'b0;
    frm.delete();
    exp_valid = 1'b0;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_col", 64'(m_col), 64'd0);
    chk("rst_m_last_col", 64'(m_last_col), 64'd0);
    chk("rst_m_rows_valid", 64'(m_rows_valid), 64'd0);
  endtask

  initial begin
    exp_valid = 1'b0; exp_data = '0; exp_col = 0; exp_last = 1'b0; exp_rv = 0; wq = 1;

    // Power-on reset
    do_reset(1'b0, 1'b1);
    do_reset(1'b0, 1'b1);

    // Fill: W=4, stream 1..12 at full rate
    curr_width = 32'd4;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0);
      if (i == 5) begin
        chk("fill_b5_data", 64'(m_data), 64'h0000_0001_0005);
        chk("fill_b5_rv", 64'(m_rows_valid), 64'd2);
      end
      if (i == 9) begin
        chk("fill_b9_data", 64'(m_data), 64'h0001_0005_0009);
        chk("fill_b9_rv", 64'(m_rows_valid), 64'd3);
        chk("fill_b9_col", 64'(m_col), 64'd0);
      end
    end

    // Backpressure mid-row: 5 stalled cycles with a pending beat, then release
    step(1'b1, DW'(13), 1'b1, 1'b0);
    step(1'b1, DW'(14), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, DW'(100 + i), 1'b0, 1'b0);
    step(1'b1, DW'(15), 1'b1, 1'b0);
    step(1'b1, DW'(16), 1'b1, 1'b0);
    step(1'b1, DW'(17), 1'b1, 1'b0);

    // Flush together with an accept mid-row, new width latched afterwards
    step(1'b1, DW'(18), 1'b1, 1'b0);
    curr_width = 32'd3;
    step(1'b1, DW'($urandom), 1'b1, 1'b1);
    step(1'b1, DW'($urandom), 1'b1, 1'b0);
    chk("flush_col", 64'(m_col), 64'd0);
    chk("flush_rv", 64'(m_rows_valid), 64'd1);
    chk("flush_upper", 64'(m_data[OW-1:DW]), 64'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 4) curr_width = 32'd7;
      step(1'($urandom_range(0, 1)) | 1'(i < 3), DW'($urandom),
           1'($urandom_range(0, 1)), 1'b0);
    end
    step(1'b0, '0, 1'b1, 1'b0);

    // W=1: stream 7,8,9
    curr_width = 32'd1;
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, DW'(7), 1'b1, 1'b0);
    step(1'b1, DW'(8), 1'b1, 1'b0);
    step(1'b1, DW'(9), 1'b1, 1'b0);
    chk("w1_data", 64'(m_data), 64'h0007_0008_0009);
    chk("w1_last", 64'(m_last_col), 64'd1);

    // Clamp: width 0 behaves as 1
    curr_width = 32'd0;
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      step(1'b1, DW'($urandom), 1'b1, 1'b0);
    chk("clamp0_last", 64'(m_last_col), 64'd1);

    // Clamp: oversize width limited to MAX_WIDTH, col wraps at MAX_WIDTH-1
    curr_width = 32'(MW + 5);
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 36; i++) begin
      step(1'b1, DW'($urandom), 1'b1, 1'b0);
      if (i == MW - 1) begin
        chk("clampmax_col", 64'(m_col), 64'(MW - 1));
        chk("clampmax_last", 64'(m_last_col), 64'd1);
      end
      if (i == MW)
        chk("clampmax_wrap", 64'(m_col), 64'd0);
    end
    for (int i = 0; i < 10; i++)
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    // Reset while FULL with a stalled output beat, then refill a new frame
    step(1'b1, DW'($urandom), 1'b1, 1'b0);
    step(1'b1, DW'($urandom), 1'b0, 1'b0);
    do_reset(1'b1, 1'b0);
    curr_width = 32'd2;
    for (int i = 0; i < 12; i++)
      step(1'b1, DW'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
